nubus_slot_bridge: RTL and testbench



---
 rtl/nubus_pkg.sv | 19 +
 rtl/nubus_irq_sync.sv | 24 ++
 rtl/nubus_slot_bridge.sv | 134 +++++++++++++
 tb/tb_nubus_slot_bridge.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nubus_pkg.sv
// Shared types and the address-window decode for the NuBus slot bridge.
package nubus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        ACK  = 3'd2,
        BERR = 3'd3,
        REL  = 3'd4
    } nubus_state_t;

    localparam logic [3:0] NUBUS_STD_PREFIX = 4'hF;

    // Standard space $Fsxx_xxxx or super-slot space $sxxx_xxxx.
    function automatic logic slot_window_hit(input logic [31:0] addr, input logic [3:0] slot);
        return (addr[31:24] == {NUBUS_STD_PREFIX, slot}) || (addr[31:28] == slot);
    endfunction

endpackage

// File: rtl/nubus_irq_sync.sv
// Two-flop synchroniser for the card's active-low interrupt request; idles high.
module nubus_irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/nubus_slot_bridge.sv
// 68k bus to single NuBus slot bridge: window decode, card strobes, ack/timeout
// handling back to the CPU, and the synchronised slot interrupt.
module nubus_slot_bridge
    import nubus_pkg::*;
#(
    parameter logic [3:0] SLOT_ID = 4'h9,
    parameter int         TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_as_n,
    input  logic        cpu_rw_n,
    input  logic        cpu_uds_n,
    input  logic        cpu_lds_n,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        cpu_dtack_n,
    output logic        cpu_berr_n,
    output logic        slot_hit,
    output logic        slot_select,
    output logic [31:0] slot_addr,
    output logic [15:0] slot_data_out,
    output logic [1:0]  slot_uds_lds,
    output logic        slot_rw_n,
    input  logic [15:0] slot_data_in,
    input  logic        slot_ack_n,
    input  logic        slot_nmrq_n,
    output logic        slot_irq_n,
    output logic        busy
);

    localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT);

    nubus_state_t state_reg;
    logic [7:0]   count_reg;
    logic         select_reg;
    logic [31:0]  addr_reg;
    logic [15:0]  data_out_reg;
    logic [1:0]   uds_lds_reg;
    logic         rw_n_reg;
    logic [15:0]  din_reg;
    logic         dtack_n_reg;
    logic         berr_n_reg;

    assign slot_hit = !cpu_as_n && slot_window_hit(cpu_addr, SLOT_ID);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            count_reg    <= 8'd0;
            select_reg   <= 1'b0;
            addr_reg     <= 32'd0;
            data_out_reg <= 16'd0;
            uds_lds_reg  <= 2'b00;
            rw_n_reg     <= 1'b1;
            din_reg      <= 16'd0;
            dtack_n_reg  <= 1'b1;
            berr_n_reg   <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (slot_hit) begin
                        state_reg    <= SEL;
                        select_reg   <= 1'b1;
                        count_reg    <= 8'd0;
                        // Both windows alias onto the same 24-bit card space.
                        addr_reg     <= {8'h00, cpu_addr[23:0]};
                        data_out_reg <= cpu_dout;
                        uds_lds_reg  <= {~cpu_uds_n, ~cpu_lds_n};
                        rw_n_reg     <= cpu_rw_n;
                    end
                end
                SEL: begin
                    // Priority: CPU abort, then card ack, then timeout.
                    if (cpu_as_n) begin
                        state_reg  <= REL;
                        select_reg <= 1'b0;
                    end else if (!slot_ack_n) begin
                        state_reg   <= ACK;
                        dtack_n_reg <= 1'b0;
                        if (rw_n_reg) begin
                            din_reg <= slot_data_in;
                        end
                    end else if (count_reg == TIMEOUT_VAL) begin
                        state_reg  <= BERR;
                        berr_n_reg <= 1'b0;
                    end else if (count_reg != 8'hFF) begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                ACK: begin
                    if (cpu_as_n) begin
                        state_reg   <= REL;
                        select_reg  <= 1'b0;
                        dtack_n_reg <= 1'b1;
                    end
                end
                BERR: begin
                    if (cpu_as_n) begin
                        state_reg  <= REL;
                        select_reg <= 1'b0;
                        berr_n_reg <= 1'b1;
                    end
                end
                REL: begin
                    // Hold off any new cycle until the card lets go of ack.
                    if (slot_ack_n) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign slot_select   = select_reg;
    assign slot_addr     = addr_reg;
    assign slot_data_out = data_out_reg;
    assign slot_uds_lds  = uds_lds_reg;
    assign slot_rw_n     = rw_n_reg;
    assign cpu_din       = din_reg;
    assign cpu_dtack_n   = dtack_n_reg;
    assign cpu_berr_n    = berr_n_reg;
    assign busy          = (state_reg != IDLE);

    nubus_irq_sync u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .d     (slot_nmrq_n),
        .q     (slot_irq_n)
    );

endmodule

// File: tb/tb_nubus_slot_bridge.sv
// Self-checking bench for nubus_slot_bridge with a behavioural card model.
module tb_nubus_slot_bridge;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic        cpu_as_n;
    logic        cpu_rw_n;
    logic        cpu_uds_n;
    logic        cpu_lds_n;
    logic [15:0] cpu_dout;
    logic [15:0] cpu_din;
    logic        cpu_dtack_n;
    logic        cpu_berr_n;
    logic        slot_hit;
    logic        slot_select;
    logic [31:0] slot_addr;
    logic [15:0] slot_data_out;
    logic [1:0]  slot_uds_lds;
    logic        slot_rw_n;
    logic [15:0] slot_data_in;
    logic        slot_ack_n;
    logic        slot_nmrq_n;
    logic        slot_irq_n;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int card_delay = 255;
    int card_cnt = 0;
    logic [15:0] exp_din = 16'h0000;

    nubus_slot_bridge #(.SLOT_ID(4'h9), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_addr      (cpu_addr),
        .cpu_as_n      (cpu_as_n),
        .cpu_rw_n      (cpu_rw_n),
        .cpu_uds_n     (cpu_uds_n),
        .cpu_lds_n     (cpu_lds_n),
        .cpu_dout      (cpu_dout),
        .cpu_din       (cpu_din),
        .cpu_dtack_n   (cpu_dtack_n),
        .cpu_berr_n    (cpu_berr_n),
        .slot_hit      (slot_hit),
        .slot_select   (slot_select),
        .slot_addr     (slot_addr),
        .slot_data_out (slot_data_out),
        .slot_uds_lds  (slot_uds_lds),
        .slot_rw_n     (slot_rw_n),
        .slot_data_in  (slot_data_in),
        .slot_ack_n    (slot_ack_n),
        .slot_nmrq_n   (slot_nmrq_n),
        .slot_irq_n    (slot_irq_n),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Card: acks card_delay cycles after it first sees select, releases when select drops.
    initial begin
        slot_ack_n = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (slot_select) begin
                card_cnt++;
                if (card_cnt > card_delay) slot_ack_n = 1'b0;
            end else begin
                card_cnt = 0;
                slot_ack_n = 1'b1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic model_hit(input logic [31:0] a);
        return ((a >> 24) == 32'hF9) || ((a >> 28) == 32'h9);
    endfunction

    // Drives one CPU cycle, observes for a fixed window, then negates AS and observes the release.
    task automatic run_txn(input logic [31:0] a, input logic rw, input logic u, input logic l,
                           input logic [15:0] wd, input logic [15:0] cd, input int dly,
                           output logic hit_seen, output int sel_k, output int ack_k, output int berr_k,
                           output logic [31:0] s_addr, output logic [1:0] s_ul, output logic s_rw,
                           output logic [15:0] s_wd, output logic [15:0] din_at,
                           output int rel_k, output int idle_k);
        @(posedge clk);
        #1;
        card_delay = dly;
        slot_data_in = cd;
        cpu_addr = a;
        cpu_rw_n = rw;
        cpu_uds_n = u;
        cpu_lds_n = l;
        cpu_dout = wd;
        cpu_as_n = 1'b0;
        #1;
        hit_seen = slot_hit;
        sel_k = 0; ack_k = 0; berr_k = 0; rel_k = 0; idle_k = 0;
        s_addr = '0; s_ul = '0; s_rw = 1'b1; s_wd = '0; din_at = '0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (slot_select && sel_k == 0) begin
                sel_k = k;
                s_addr = slot_addr;
                s_ul = slot_uds_lds;
                s_rw = slot_rw_n;
                s_wd = slot_data_out;
            end
            if (!cpu_dtack_n && ack_k == 0) begin
                ack_k = k;
                din_at = cpu_din;
            end
            if (!cpu_berr_n && berr_k == 0) berr_k = k;
        end
        cpu_as_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (!slot_select && cpu_dtack_n && cpu_berr_n && rel_k == 0) rel_k = k;
            if (!busy && idle_k == 0) idle_k = k;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_addr = '0; cpu_as_n = 1'b1; cpu_rw_n = 1'b1; cpu_uds_n = 1'b1; cpu_lds_n = 1'b1;
        cpu_dout = '0; slot_data_in = '0; slot_nmrq_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({slot_select, slot_addr, slot_data_out, slot_uds_lds, slot_rw_n} !== {1'b0, 32'h0, 16'h0, 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL reset_slot: got sel=%b addr=%h data=%h ul=%b rw=%b want 0/0/0/00/1",
                     slot_select, slot_addr, slot_data_out, slot_uds_lds, slot_rw_n);
        end
        checks++;
        if ({cpu_din, cpu_dtack_n, cpu_berr_n, slot_irq_n, busy} !== {16'h0, 1'b1, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_cpu: got din=%h dtack=%b berr=%b irq=%b busy=%b want 0000/1/1/1/0",
                     cpu_din, cpu_dtack_n, cpu_berr_n, slot_irq_n, busy);
        end
        $display("txn reset done");
    endtask

    task automatic test_read();
        logic h, srw; int sk, ak, bk, rk, ik; logic [31:0] sa; logic [1:0] sul; logic [15:0] swd, dat;
        run_txn(32'hF900_0000, 1'b1, 1'b0, 1'b0, 16'h0, 16'hA5C3, 1, h, sk, ak, bk, sa, sul, srw, swd, dat, rk, ik);
        exp_din = 16'hA5C3;
        checks++;
        if ({h, sk, ak, bk} !== {1'b1, 32'd1, 32'd3, 32'd0}) begin
            errors++;
            $display("FAIL read_timing: got hit=%b sel_k=%0d ack_k=%0d berr_k=%0d want 1/1/3/0", h, sk, ak, bk);
        end
        checks++;
        if (dat !== 16'hA5C3) begin
            errors++;
            $display("FAIL read_data: got %h want a5c3", dat);
        end
        checks++;
        if ({rk, ik} !== {32'd1, 32'd2}) begin
            errors++;
            $display("FAIL read_release: got rel_k=%0d idle_k=%0d want 1/2", rk, ik);
        end
        $display("txn read F9000000 din=%h ack_k=%0d", dat, ak);
    endtask

    task automatic test_write();
        logic h, srw; int sk, ak, bk, rk, ik; logic [31:0] sa; logic [1:0] sul; logic [15:0] swd, dat;
        run_txn(32'hF980_0000, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h5555, 1, h, sk, ak, bk, sa, sul, srw, swd, dat, rk, ik);
        checks++;
        if ({sa, sul, srw, swd} !== {32'h0080_0000, 2'b10, 1'b0, 16'h8000}) begin
            errors++;
            $display("FAIL write_strobes: got addr=%h ul=%b rw=%b data=%h want 00800000/10/0/8000", sa, sul, srw, swd);
        end
        checks++;
        if ({ak, bk} !== {32'd3, 32'd0}) begin
            errors++;
            $display("FAIL write_dtack: got ack_k=%0d berr_k=%0d want 3/0", ak, bk);
        end
        checks++;
        if (cpu_din !== exp_din) begin
            errors++;
            $display("FAIL write_din_hold: got %h want %h", cpu_din, exp_din);
        end
        $display("txn write F9800000 addr=%h ul=%b", sa, sul);
    endtask

    task automatic test_super_and_miss();
        logic h, srw; int sk, ak, bk, rk, ik; logic [31:0] sa; logic [1:0] sul; logic [15:0] swd, dat;
        run_txn(32'h9012_3456, 1'b1, 1'b0, 1'b0, 16'h0, 16'h1234, 2, h, sk, ak, bk, sa, sul, srw, swd, dat, rk, ik);
        exp_din = 16'h1234;
        checks++;
        if ({sa, ak, dat} !== {32'h0012_3456, 32'd4, 16'h1234}) begin
            errors++;
            $display("FAIL super_read: got addr=%h ack_k=%0d din=%h want 00123456/4/1234", sa, ak, dat);
        end
        $display("txn super 90123456 addr=%h", sa);
        run_txn(32'hFA00_0000, 1'b1, 1'b0, 1'b0, 16'h0, 16'hFFFF, 1, h, sk, ak, bk, sa, sul, srw, swd, dat, rk, ik);
        checks++;
        if ({h, sk, ak, bk, ik} !== {1'b0, 32'd0, 32'd0, 32'd0, 32'd1}) begin
            errors++;
            $display("FAIL miss: got hit=%b sel_k=%0d ack_k=%0d berr_k=%0d idle_k=%0d want 0/0/0/0/1", h, sk, ak, bk, ik);
        end
        $display("txn miss FA000000 hit=%b", h);
    endtask

    task automatic test_timeout();
        logic h, srw; int sk, ak, bk, rk, ik; logic [31:0] sa; logic [1:0] sul; logic [15:0] swd, dat;
        run_txn(32'hF900_0010, 1'b1, 1'b0, 1'b0, 16'h0, 16'hDEAD, 255, h, sk, ak, bk, sa, sul, srw, swd, dat, rk, ik);
        checks++;
        if ({sk, ak, bk} !== {32'd1, 32'd0, 32'd18}) begin
            errors++;
            $display("FAIL timeout_berr: got sel_k=%0d ack_k=%0d berr_k=%0d want 1/0/18", sk, ak, bk);
        end
        checks++;
        if ({rk, ik, cpu_din} !== {32'd1, 32'd2, exp_din}) begin
            errors++;
            $display("FAIL timeout_release: got rel_k=%0d idle_k=%0d din=%h want 1/2/%h", rk, ik, cpu_din, exp_din);
        end
        $display("txn timeout berr_k=%0d", bk);
        // Ack on the very cycle the count expires: ack takes priority.
        run_txn(32'hF900_0020, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0F0F, TO, h, sk, ak, bk, sa, sul, srw, swd, dat, rk, ik);
        exp_din = 16'h0F0F;
        checks++;
        if ({ak, bk, dat} !== {32'd18, 32'd0, 16'h0F0F}) begin
            errors++;
            $display("FAIL ack_vs_timeout: got ack_k=%0d berr_k=%0d din=%h want 18/0/0f0f", ak, bk, dat);
        end
        run_txn(32'hF900_0030, 1'b1, 1'b0, 1'b0, 16'h0, 16'hF0F0, TO + 1, h, sk, ak, bk, sa, sul, srw, swd, dat, rk, ik);
        checks++;
        if ({ak, bk, cpu_din} !== {32'd0, 32'd18, exp_din}) begin
            errors++;
            $display("FAIL late_ack: got ack_k=%0d berr_k=%0d din=%h want 0/18/%h", ak, bk, cpu_din, exp_din);
        end
        $display("txn boundary acks done");
    endtask

    task automatic test_abort();
        logic dt_seen;
        @(posedge clk);
        #1;
        card_delay = 1;
        slot_data_in = 16'hBEEF;
        cpu_addr = 32'hF900_0040; cpu_rw_n = 1'b1; cpu_uds_n = 1'b0; cpu_lds_n = 1'b0;
        cpu_as_n = 1'b0;
        dt_seen = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (slot_select !== 1'b1) begin
            errors++;
            $display("FAIL abort_select_rise: got %b want 1", slot_select);
        end
        @(posedge clk);
        #1;
        cpu_as_n = 1'b1;
        if (!cpu_dtack_n) dt_seen = 1'b1;
        @(posedge clk);
        #1;
        if (!cpu_dtack_n) dt_seen = 1'b1;
        checks++;
        if ({slot_select, dt_seen, cpu_din} !== {1'b0, 1'b0, exp_din}) begin
            errors++;
            $display("FAIL abort: got sel=%b dtack_seen=%b din=%h want 0/0/%h", slot_select, dt_seen, cpu_din, exp_din);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b want 0", busy);
        end
        $display("txn abort sel=%b dtack_seen=%b", slot_select, dt_seen);
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        card_delay = 1;
        slot_data_in = 16'h7777;
        cpu_addr = 32'hF900_0050; cpu_rw_n = 1'b1; cpu_as_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cpu_dtack_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ack: got dtack=%b want 0", cpu_dtack_n);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({cpu_dtack_n, slot_select, busy, cpu_din} !== {1'b1, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("FAIL reset_mid: got dtack=%b sel=%b busy=%b din=%h want 1/0/0/0000",
                     cpu_dtack_n, slot_select, busy, cpu_din);
        end
        cpu_as_n = 1'b1;
        exp_din = 16'h0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        $display("txn reset_mid dtack=%b", cpu_dtack_n);
    endtask

    task automatic test_irq();
        @(posedge clk);
        #1;
        slot_nmrq_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (slot_irq_n !== 1'b1) begin
            errors++;
            $display("FAIL irq_assert_early: got %b want 1", slot_irq_n);
        end
        @(posedge clk);
        #1;
        checks++;
        if (slot_irq_n !== 1'b0) begin
            errors++;
            $display("FAIL irq_assert: got %b want 0", slot_irq_n);
        end
        slot_nmrq_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (slot_irq_n !== 1'b0) begin
            errors++;
            $display("FAIL irq_release_early: got %b want 0", slot_irq_n);
        end
        @(posedge clk);
        #1;
        checks++;
        if (slot_irq_n !== 1'b1) begin
            errors++;
            $display("FAIL irq_release: got %b want 1", slot_irq_n);
        end
        $display("txn irq done");
    endtask

    task automatic test_random();
        logic h, srw, rw, u, l, eh; int sk, ak, bk, rk, ik, dly, kind;
        logic [31:0] a, sa; logic [1:0] sul; logic [15:0] swd, dat, wd, cd;
        for (int t = 0; t < 14; t++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0)      a = {8'hF9, 24'($urandom)};
            else if (kind == 1) a = {4'h9, 28'($urandom)};
            else                a = $urandom;
            rw = 1'($urandom); u = 1'($urandom); l = 1'($urandom);
            wd = 16'($urandom); cd = 16'($urandom);
            dly = $urandom_range(0, 20);
            run_txn(a, rw, u, l, wd, cd, dly, h, sk, ak, bk, sa, sul, srw, swd, dat, rk, ik);
            eh = model_hit(a);
            checks++;
            if (h !== eh) begin
                errors++;
                $display("FAIL rnd_hit: addr=%h got %b want %b", a, h, eh);
            end
            if (eh) begin
                checks++;
                if ({sk, sa, sul, srw} !== {32'd1, a & 32'h00FF_FFFF, ~u, ~l, rw}) begin
                    errors++;
                    $display("FAIL rnd_strobes: addr=%h got sel_k=%0d addr=%h ul=%b rw=%b", a, sk, sa, sul, srw);
                end
                checks++;
                if (dly <= TO) begin
                    if ({ak, bk} !== {dly + 2, 32'd0}) begin
                        errors++;
                        $display("FAIL rnd_ack: dly=%0d got ack_k=%0d berr_k=%0d want %0d/0", dly, ak, bk, dly + 2);
                    end
                end else if ({ak, bk} !== {32'd0, TO + 2}) begin
                    errors++;
                    $display("FAIL rnd_berr: dly=%0d got ack_k=%0d berr_k=%0d want 0/%0d", dly, ak, bk, TO + 2);
                end
                if (rw && dly <= TO) exp_din = cd;
                if (!rw) begin
                    checks++;
                    if (swd !== wd) begin
                        errors++;
                        $display("FAIL rnd_wdata: got %h want %h", swd, wd);
                    end
                end
            end
            checks++;
            if ({cpu_din, ik} !== {exp_din, eh ? 32'd2 : 32'd1}) begin
                errors++;
                $display("FAIL rnd_end: got din=%h idle_k=%0d want %h/%0d", cpu_din, ik, exp_din, eh ? 2 : 1);
            end
            $display("txn rnd %0d addr=%h rw=%b dly=%0d hit=%b ack_k=%0d berr_k=%0d", t, a, rw, dly, h, ak, bk);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_super_and_miss();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_irq();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
